// File: rtl/huff_bit_chunker.sv
// Byte-to-chunk slicer feeding the Huffman decoder shift register.
// Bytes enter a left-aligned bit reservoir; chunks of up to CHUNK_MAX bits leave from its head.
module huff_bit_chunker #(
    parameter int CHUNK_MAX = 4,
    parameter int RES_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    input  logic [2:0]           s_last_bits,
    output logic                 s_ready,
    output logic [CHUNK_MAX-1:0] m_bits,
    output logic [2:0]           m_len,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    localparam logic [4:0] CMAX = 5'(CHUNK_MAX);
    localparam logic [4:0] RLIM = 5'(RES_BITS - 8);

    state_t              state_q;
    logic [4:0]          count_q;
    logic [4:0]          count_d;
    logic [RES_BITS-1:0] res_q;
    logic [RES_BITS-1:0] res_d;

    logic [4:0]           len5;
    logic [4:0]           n5;
    logic [4:0]           pos;
    logic [7:0]           byte_m;
    logic [CHUNK_MAX-1:0] head;
    logic [RES_BITS-1:0]  shifted;
    logic [RES_BITS-1:0]  ext;
    logic                 accept;
    logic                 consume;

    always_comb begin
        len5    = (count_q >= CMAX) ? CMAX : count_q;
        head    = res_q[RES_BITS-1 -: CHUNK_MAX];
        m_len   = len5[2:0];
        m_bits  = head >> (CMAX - len5);
        m_valid = (count_q >= CMAX) || (state_q == DRAIN && count_q != 5'd0);
        m_last  = (state_q == DRAIN) && (count_q <= CMAX);
        s_ready = reset && (state_q != DRAIN) && (count_q <= RLIM);
    end

    // New bits land right after whatever survives this cycle's consume.
    always_comb begin
        accept  = s_valid && s_ready;
        consume = m_valid && m_ready;
        n5      = (s_last && s_last_bits != 3'd0) ? {2'b00, s_last_bits} : 5'd8;
        byte_m  = s_data & (8'hFF << (5'd8 - n5));
        pos     = count_q - (consume ? len5 : 5'd0);
        shifted = consume ? (res_q << len5) : res_q;
        ext     = {byte_m, {(RES_BITS-8){1'b0}}} >> pos;
        res_d   = accept ? (shifted | ext) : shifted;
        count_d = pos + (accept ? n5 : 5'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= 5'd0;
            res_q   <= '0;
        end else begin
            count_q <= count_d;
            res_q   <= res_d;
            case (state_q)
                IDLE: begin
                    if (accept) state_q <= s_last ? DRAIN : STREAM;
                end
                STREAM: begin
                    if (accept && s_last) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (consume && m_last) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_huff_bit_chunker.sv
// Scoreboard bench for huff_bit_chunker: directed frames plus random frames
// checked against a bit-queue reference model.
module tb_huff_bit_chunker;

    typedef struct packed {
        logic [3:0] bits;
        logic [2:0] len;
        logic       last;
    } chunk_t;

    logic       clk = 0;
    logic       reset = 0;
    logic [7:0] s_data = 0;
    logic       s_valid = 0;
    logic       s_last = 0;
    logic [2:0] s_last_bits = 0;
    logic       s_ready;
    logic [3:0] m_bits;
    logic [2:0] m_len;
    logic       m_valid;
    logic       m_last;
    logic       m_ready = 0;

    int     total = 0;
    int     bad = 0;
    chunk_t exp_q[$];
    bit     rnd_on = 0;
    bit     stall = 0;
    chunk_t held;

    huff_bit_chunker #(.CHUNK_MAX(4), .RES_BITS(16)) dut (
        .clk(clk),
        .reset(reset),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_last(s_last),
        .s_last_bits(s_last_bits),
        .s_ready(s_ready),
        .m_bits(m_bits),
        .m_len(m_len),
        .m_valid(m_valid),
        .m_last(m_last),
        .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] b, input logic [2:0] l, input logic last);
        chunk_t c;
        c.bits = b;
        c.len  = l;
        c.last = last;
        exp_q.push_back(c);
    endtask

    task automatic send(input logic [7:0] d, input logic last, input logic [2:0] lb);
        int g;
        bit acc;
        g = 0;
        acc = 0;
        s_data = d;
        s_last = last;
        s_last_bits = lb;
        s_valid = 1;
        while (!acc && g < 300) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            g++;
        end
        s_valid = 0;
        s_last = 0;
        s_last_bits = 0;
        if (!acc) chk("send_timeout", 32'(acc), 1);
    endtask

    task automatic wait_empty();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    // Scoreboard monitor: pops on each consume, checks hold stability on stalls.
    always @(negedge clk) begin
        if (!reset) begin
            stall = 0;
        end else begin
            if (stall) begin
                chk("stall_valid", 32'(m_valid), 1);
                chk("stall_hold", {24'd0, m_bits, m_len, m_last}, {24'd0, held});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_chunk", {24'd0, m_bits, m_len, m_last}, 0);
                end else begin
                    chk("chunk", {24'd0, m_bits, m_len, m_last}, {24'd0, exp_q.pop_front()});
                end
            end
            stall = m_valid && !m_ready;
            held  = {m_bits, m_len, m_last};
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rnd_on) m_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fb[4];
        bit         bq[$];
        int         nb;
        int         n;
        int         l;
        logic [2:0] lb;
        logic [3:0] v;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_m_bits", 32'(m_bits), 0);
        chk("rst_m_len", 32'(m_len), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("post_rst_s_ready", 32'(s_ready), 1);
        @(posedge clk);
        #1;

        m_ready = 1;
        push(4'hA, 3'd4, 0);
        push(4'h5, 3'd4, 1);
        send(8'hA5, 1, 3'd0);
        wait_empty();

        push(4'h3, 3'd4, 0);
        push(4'hC, 3'd4, 0);
        push(4'h7, 3'd3, 1);
        send(8'h3C, 0, 3'd0);
        send(8'hE0, 1, 3'd3);
        wait_empty();

        m_ready = 0;
        push(4'hF, 3'd4, 0);
        push(4'h0, 3'd4, 0);
        push(4'h0, 3'd4, 0);
        push(4'hF, 3'd4, 0);
        push(4'h8, 3'd4, 0);
        push(4'h1, 3'd4, 1);
        send(8'hF0, 0, 3'd0);
        send(8'h0F, 0, 3'd0);
        fork
            send(8'h81, 1, 3'd0);
            begin
                @(negedge clk);
                chk("full_s_ready", 32'(s_ready), 0);
                chk("full_m_bits", 32'(m_bits), 32'hF);
                chk("full_m_len", 32'(m_len), 4);
                repeat (2) @(posedge clk);
                #1;
                m_ready = 1;
            end
        join
        wait_empty();

        m_ready = 0;
        push(4'hA, 3'd4, 0);
        send(8'hAB, 0, 3'd0);
        m_ready = 1;
        @(posedge clk);
        #1;
        m_ready = 0;
        send(8'hCD, 0, 3'd0);
        @(negedge clk);
        chk("pre_rst_m_bits", 32'(m_bits), 32'hB);
        chk("pre_rst_s_ready", 32'(s_ready), 0);
        reset = 0;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 0);
        chk("mid_rst_s_ready", 32'(s_ready), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("rel_s_ready", 32'(s_ready), 1);
        chk("rel_m_valid", 32'(m_valid), 0);
        @(posedge clk);
        #1;
        m_ready = 1;
        push(4'h5, 3'd4, 0);
        push(4'hA, 3'd4, 1);
        send(8'h5A, 1, 3'd0);
        wait_empty();

        push(4'h1, 3'd4, 0);
        push(4'h2, 3'd4, 0);
        push(4'h1, 3'd1, 1);
        send(8'h12, 0, 3'd0);
        send(8'h80, 1, 3'd1);
        wait_empty();

        rnd_on = 1;
        for (int f = 0; f < 60; f++) begin
            nb = $urandom_range(1, 4);
            lb = 3'($urandom_range(0, 7));
            bq.delete();
            for (int i = 0; i < nb; i++) begin
                fb[i] = 8'($urandom_range(0, 255));
                n = (i == nb - 1 && lb != 0) ? int'(lb) : 8;
                for (int k = 0; k < n; k++) bq.push_back(fb[i][7-k]);
            end
            while (bq.size() > 0) begin
                l = (bq.size() < 4) ? bq.size() : 4;
                v = 0;
                for (int k = 0; k < l; k++) v = {v[2:0], bq.pop_front()};
                push(v, 3'(l), bq.size() == 0);
            end
            for (int i = 0; i < nb; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send(fb[i], i == nb - 1, lb);
            end
        end
        rnd_on = 0;
        @(posedge clk);
        #1;
        m_ready = 1;
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
